// File: rtl/traffic_pkg.sv
// Shared traffic-controller definitions: phase encoding and lane-count ceiling.
// Used by the auto sequencer, the manual-mode block and the lamp decoder.
package traffic_pkg;

    localparam int unsigned MAX_LANES = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } phase_t;

endpackage

// File: rtl/lane_phase_sequencer_phase_timer.sv
// Phase countdown: loads a duration (0 clamps to 1), counts down to 1 and holds.
// last flags the final cycle of the loaded interval.
module phase_timer #(
    parameter int TIME_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [TIME_W-1:0] load_value,
    output logic [TIME_W-1:0] time_left,
    output logic              last
);

    logic [TIME_W-1:0] load_clamped;

    assign load_clamped = (load_value == '0) ? TIME_W'(1) : load_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_left <= '0;
        end else if (clear) begin
            time_left <= '0;
        end else if (load) begin
            time_left <= load_clamped;
        end else if (time_left > TIME_W'(1)) begin
            time_left <= time_left - TIME_W'(1);
        end
    end

    assign last = (time_left == TIME_W'(1));

endmodule

// File: rtl/lane_phase_sequencer.sv
// N-lane round-robin green/yellow sequencer with demand-based lane skipping.
// Define TRAFFIC_ALLRED_EN to insert an all-red clearance phase after each yellow.
module lane_phase_sequencer
    import traffic_pkg::*;
#(
    parameter  int NUM_LANES = 4,
    parameter  int TIME_W    = 7,
    localparam int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [TIME_W-1:0]    green_time,
    input  logic [TIME_W-1:0]    yellow_time,
    input  logic [TIME_W-1:0]    allred_time,
    input  logic [NUM_LANES-1:0] skip_mask,
    output logic [LANE_W-1:0]    active_lane,
    output logic [1:0]           phase,
    output logic [TIME_W-1:0]    time_left,
    output logic [NUM_LANES-1:0] lamp_green,
    output logic [NUM_LANES-1:0] lamp_yellow,
    output logic [NUM_LANES-1:0] lamp_red,
    output logic                 phase_done
);

    localparam int unsigned NL = NUM_LANES;

    phase_t              state;
    logic [LANE_W-1:0]   lane_q;
    logic [LANE_W-1:0]   first_lane;
    logic [LANE_W-1:0]   next_lane;
    logic                tmr_clear;
    logic                tmr_load;
    logic [TIME_W-1:0]   tmr_value;
    logic                tmr_last;
    logic [NUM_LANES-1:0] lane_onehot;

`ifndef TRAFFIC_ALLRED_EN
    logic unused_allred;
    assign unused_allred = ^allred_time;
`endif

    // Lowest lane with demand; lane 0 when every lane is skipped.
    always_comb begin
        logic found;
        first_lane = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NL; i++) begin
            logic [LANE_W-1:0] cand;
            cand = LANE_W'(i);
            if (!found && !skip_mask[cand]) begin
                first_lane = cand;
                found      = 1'b1;
            end
        end
    end

    // Round-robin successor over the other NL-1 lanes; repeat current lane if none.
    always_comb begin
        logic found;
        next_lane = lane_q;
        found     = 1'b0;
        for (int unsigned k = 1; k < NL; k++) begin
            logic [LANE_W-1:0] cand;
            cand = LANE_W'((32'(lane_q) + k) % NL);
            if (!found && !skip_mask[cand]) begin
                next_lane = cand;
                found     = 1'b1;
            end
        end
    end

    // Timer reloads on every phase entry, so durations are sampled only there.
    always_comb begin
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = green_time;
        if (!enable) begin
            tmr_clear = 1'b1;
        end else begin
            case (state)
                IDLE: tmr_load = 1'b1;
                GREEN: begin
                    if (tmr_last) begin
                        tmr_load  = 1'b1;
                        tmr_value = yellow_time;
                    end
                end
                YELLOW: begin
                    if (tmr_last) begin
                        tmr_load = 1'b1;
`ifdef TRAFFIC_ALLRED_EN
                        tmr_value = allred_time;
`endif
                    end
                end
`ifdef TRAFFIC_ALLRED_EN
                ALLRED: begin
                    if (tmr_last) tmr_load = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    phase_timer #(
        .TIME_W(TIME_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (tmr_clear),
        .load      (tmr_load),
        .load_value(tmr_value),
        .time_left (time_left),
        .last      (tmr_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            lane_q <= '0;
        end else if (!enable) begin
            state  <= IDLE;
            lane_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= GREEN;
                    lane_q <= first_lane;
                end
                GREEN: begin
                    if (tmr_last) state <= YELLOW;
                end
                YELLOW: begin
                    if (tmr_last) begin
`ifdef TRAFFIC_ALLRED_EN
                        state <= ALLRED;
`else
                        state  <= GREEN;
                        lane_q <= next_lane;
`endif
                    end
                end
`ifdef TRAFFIC_ALLRED_EN
                ALLRED: begin
                    if (tmr_last) begin
                        state  <= GREEN;
                        lane_q <= next_lane;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    lane_q <= '0;
                end
            endcase
        end
    end

    assign active_lane = lane_q;
    assign phase       = state;
    assign phase_done  = tmr_last;

    assign lane_onehot = NUM_LANES'(1) << lane_q;
    assign lamp_green  = (state == GREEN)  ? lane_onehot : '0;
    assign lamp_yellow = (state == YELLOW) ? lane_onehot : '0;
    assign lamp_red    = ~(lamp_green | lamp_yellow);

    a_lamp_cover: assert property (@(posedge clk) disable iff (reset)
        ((lamp_green | lamp_yellow | lamp_red) == '1));

    a_timed_nonzero: assert property (@(posedge clk) disable iff (reset)
        ((state != IDLE) -> (time_left != '0)));

`ifndef TRAFFIC_ALLRED_EN
    a_no_allred: assert property (@(posedge clk) disable iff (reset)
        (state != ALLRED));
`endif

endmodule

// File: tb/tb_lane_phase_sequencer.sv
// Randomised self-checking bench for lane_phase_sequencer against a schedule-queue model.
// Honours TRAFFIC_ALLRED_EN the same way as the design.
module tb_lane_phase_sequencer;

    localparam int NL = 4;
    localparam int TW = 7;
    localparam int LW = 2;
    localparam int VW = 2 + LW + TW + 3 * NL + 1;
`ifdef TRAFFIC_ALLRED_EN
    localparam bit AR_ON = 1'b1;
`else
    localparam bit AR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [TW-1:0] green_time = '0;
    logic [TW-1:0] yellow_time = '0;
    logic [TW-1:0] allred_time = '0;
    logic [NL-1:0] skip_mask = '0;
    logic [LW-1:0] active_lane;
    logic [1:0]    phase;
    logic [TW-1:0] time_left;
    logic [NL-1:0] lamp_green;
    logic [NL-1:0] lamp_yellow;
    logic [NL-1:0] lamp_red;
    logic          phase_done;

    int n_checks = 0;
    int n_fail = 0;

    lane_phase_sequencer #(
        .NUM_LANES(NL),
        .TIME_W   (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .green_time (green_time),
        .yellow_time(yellow_time),
        .allred_time(allred_time),
        .skip_mask  (skip_mask),
        .active_lane(active_lane),
        .phase      (phase),
        .time_left  (time_left),
        .lamp_green (lamp_green),
        .lamp_yellow(lamp_yellow),
        .lamp_red   (lamp_red),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    // Reference: a queue holding one entry per remaining cycle of the planned phase.
    typedef struct {
        logic [1:0] ph;
        int         lane;
        int         tl;
    } ent_t;

    ent_t q[$];
    ent_t e_done;

    function automatic int m_first(input logic [NL-1:0] m);
        for (int i = 0; i < NL; i++) if (!m[LW'(i)]) return i;
        return 0;
    endfunction

    function automatic int m_next(input int cur, input logic [NL-1:0] m);
        for (int k = 1; k < NL; k++) if (!m[LW'((cur + k) % NL)]) return (cur + k) % NL;
        return cur;
    endfunction

    function automatic void m_plan(input logic [1:0] ph, input int lane, input logic [TW-1:0] dur);
        ent_t e;
        int d;
        d = (dur == '0) ? 1 : int'(dur);
        for (int t = d; t >= 1; t--) begin
            e.ph = ph;
            e.lane = lane;
            e.tl = t;
            q.push_back(e);
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset || !enable) begin
            q.delete();
        end else if (q.size() == 0) begin
            m_plan(2'd1, m_first(skip_mask), green_time);
        end else begin
            e_done = q.pop_front();
            if (q.size() == 0) begin
                if (e_done.ph == 2'd1) m_plan(2'd2, e_done.lane, yellow_time);
                else if (e_done.ph == 2'd2 && AR_ON) m_plan(2'd3, e_done.lane, allred_time);
                else m_plan(2'd1, m_next(e_done.lane, skip_mask), green_time);
            end
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic [1:0]    ph;
        int            ln;
        int            tl;
        logic [NL-1:0] g;
        logic [NL-1:0] y;
        logic [NL-1:0] r;
        ph = 2'd0; ln = 0; tl = 0;
        g = '0; y = '0; r = '1;
        if (q.size() > 0) begin
            ph = q[0].ph; ln = q[0].lane; tl = q[0].tl;
        end
        if (ph == 2'd1) begin g[LW'(ln)] = 1'b1; r[LW'(ln)] = 1'b0; end
        else if (ph == 2'd2) begin y[LW'(ln)] = 1'b1; r[LW'(ln)] = 1'b0; end
        return {ph, LW'(ln), TW'(tl), g, y, r, (tl == 1)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {phase, active_lane, time_left, lamp_green, lamp_yellow, lamp_red, phase_done};
    endfunction

    task automatic restart(input logic [NL-1:0] m, input logic [TW-1:0] g,
                           input logic [TW-1:0] y, input logic [TW-1:0] a);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        skip_mask = m; green_time = g; yellow_time = y; allred_time = a;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({phase, active_lane, time_left} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h required 0", {phase, active_lane, time_left});
        end
        n_checks++;
        if ({lamp_green, lamp_yellow, lamp_red, phase_done} !== {4'h0, 4'h0, 4'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_lamps: got g=%b y=%b r=%b done=%b required g=0000 y=0000 r=1111 done=0",
                     lamp_green, lamp_yellow, lamp_red, phase_done);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h required %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_rotation();
        int ent_lane[$];
        int ent_cyc[$];
        int per;
        per = 4 * (5 + 2 + (AR_ON ? 1 : 0));
        skip_mask = '0; green_time = 7'd5; yellow_time = 7'd2; allred_time = 7'd1;
        enable = 1'b1;
        for (int c = 0; c < per + 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rotation_c%0d: got %h required %h", c, obs_vec(), exp_vec());
            end
            if (phase == 2'd1 && time_left == 7'd5) begin
                ent_lane.push_back(int'(active_lane));
                ent_cyc.push_back(c);
            end
        end
        n_checks++;
        if (ent_cyc.size() < 5) begin
            n_fail++;
            $display("FAIL rotation_entries: got %0d green entries required >=5", ent_cyc.size());
        end else begin
            n_checks++;
            if (ent_cyc[0] != 0) begin
                n_fail++;
                $display("FAIL first_green_latency: got cycle %0d required 0", ent_cyc[0]);
            end
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (ent_lane[i] != i % 4) begin
                    n_fail++;
                    $display("FAIL rotation_lane%0d: got %0d required %0d", i, ent_lane[i], i % 4);
                end
            end
            n_checks++;
            if (ent_cyc[4] - ent_cyc[0] != per) begin
                n_fail++;
                $display("FAIL rotation_period: got %0d required %0d", ent_cyc[4] - ent_cyc[0], per);
            end
        end
    endtask

    task automatic test_skip();
        int ent[$];
        restart(4'b0110, 7'd5, 7'd2, 7'd1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL skip0110_c%0d: got %h required %h", c, obs_vec(), exp_vec());
            end
            if (phase == 2'd1 && time_left == 7'd5) ent.push_back(int'(active_lane));
        end
        n_checks++;
        if (ent.size() < 4) begin
            n_fail++;
            $display("FAIL skip0110_entries: got %0d required >=4", ent.size());
        end
        for (int i = 0; i < ent.size(); i++) begin
            n_checks++;
            if (ent[i] != ((i % 2 == 0) ? 0 : 3)) begin
                n_fail++;
                $display("FAIL skip0110_lane%0d: got %0d required %0d", i, ent[i], (i % 2 == 0) ? 0 : 3);
            end
        end
        ent.delete();
        restart(4'b1111, 7'd5, 7'd2, 7'd1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL skip1111_c%0d: got %h required %h", c, obs_vec(), exp_vec());
            end
            if (phase == 2'd1 && time_left == 7'd5) ent.push_back(int'(active_lane));
        end
        n_checks++;
        if (ent.size() < 3) begin
            n_fail++;
            $display("FAIL skip1111_entries: got %0d required >=3", ent.size());
        end
        for (int i = 0; i < ent.size(); i++) begin
            n_checks++;
            if (ent[i] != 0) begin
                n_fail++;
                $display("FAIL skip1111_lane%0d: got %0d required 0", i, ent[i]);
            end
        end
    endtask

    task automatic test_duration_change();
        logic [1:0] run_ph[$];
        int         run_len[$];
        logic [1:0] cur;
        int         len;
        int         ig;
        cur = 2'd0; len = 0;
        restart(4'b0000, 7'd5, 7'd2, 7'd1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL durchg_c%0d: got %h required %h", c, obs_vec(), exp_vec());
            end
            if (c == 0 || phase != cur) begin
                if (c > 0) begin run_ph.push_back(cur); run_len.push_back(len); end
                cur = phase; len = 1;
            end else begin
                len++;
            end
            if (c == 1) begin green_time = 7'd9; yellow_time = 7'd0; end
        end
        ig = AR_ON ? 3 : 2;
        n_checks++;
        if (run_ph.size() < ig + 1) begin
            n_fail++;
            $display("FAIL durchg_runs: got %0d runs required >=%0d", run_ph.size(), ig + 1);
        end else begin
            n_checks++;
            if ({run_ph[0], 7'(run_len[0])} !== {2'd1, 7'd5}) begin
                n_fail++;
                $display("FAIL durchg_green1: got ph=%0d len=%0d required ph=1 len=5", run_ph[0], run_len[0]);
            end
            n_checks++;
            if ({run_ph[1], 7'(run_len[1])} !== {2'd2, 7'd1}) begin
                n_fail++;
                $display("FAIL durchg_yellow0: got ph=%0d len=%0d required ph=2 len=1", run_ph[1], run_len[1]);
            end
            n_checks++;
            if ({run_ph[ig], 7'(run_len[ig])} !== {2'd1, 7'd9}) begin
                n_fail++;
                $display("FAIL durchg_green2: got ph=%0d len=%0d required ph=1 len=9", run_ph[ig], run_len[ig]);
            end
        end
    endtask

    task automatic test_enable_drop();
        bit found;
        found = 1'b0;
        restart(4'b0000, 7'd5, 7'd2, 7'd1);
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL endrop_c%0d: got %h required %h", c, obs_vec(), exp_vec());
            end
            if (phase == 2'd1 && active_lane == 2'd2 && time_left == 7'd3) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL endrop_wait: got no third green cycle of lane 2 required one within 200 cycles");
        end else begin
            enable = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({phase, time_left, lamp_green, lamp_yellow, lamp_red} !== {2'd0, 7'd0, 4'h0, 4'h0, 4'hF}) begin
                n_fail++;
                $display("FAIL endrop_idle: got ph=%0d tl=%0d r=%b g=%b y=%b required ph=0 tl=0 r=1111 g=0000 y=0000",
                         phase, time_left, lamp_red, lamp_green, lamp_yellow);
            end
            skip_mask = 4'b0011;
            enable = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({phase, active_lane, time_left} !== {2'd1, 2'd2, 7'd5}) begin
                n_fail++;
                $display("FAIL endrop_restart: got ph=%0d lane=%0d tl=%0d required ph=1 lane=2 tl=5",
                         phase, active_lane, time_left);
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL endrop_model: got %h required %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        restart(4'b0000, 7'd5, 7'd2, 7'd1);
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (phase == 2'd2) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL areset_wait: got no yellow required one within 100 cycles");
        end else begin
            reset = 1'b1;
            #1;
            n_checks++;
            if ({phase, active_lane, time_left, lamp_green, lamp_yellow, lamp_red, phase_done}
                !== {2'd0, 2'd0, 7'd0, 4'h0, 4'h0, 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL areset_immediate: got ph=%0d lane=%0d tl=%0d g=%b y=%b r=%b done=%b required idle values",
                         phase, active_lane, time_left, lamp_green, lamp_yellow, lamp_red, phase_done);
            end
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({phase, active_lane, time_left} !== {2'd1, 2'd0, 7'd5}) begin
                n_fail++;
                $display("FAIL areset_release: got ph=%0d lane=%0d tl=%0d required ph=1 lane=0 tl=5",
                         phase, active_lane, time_left);
            end
        end
    endtask

    task automatic test_long_green();
        int done_at[$];
        restart(4'b1010, 7'd127, 7'd3, 7'd1);
        for (int c = 1; c <= 135; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL long_c%0d: got %h required %h", c, obs_vec(), exp_vec());
            end
            if (phase_done) done_at.push_back(c);
        end
        n_checks++;
        if (done_at.size() < 2) begin
            n_fail++;
            $display("FAIL long_done_count: got %0d pulses required >=2", done_at.size());
        end else begin
            n_checks++;
            if (done_at[0] != 127 || done_at[1] != 130) begin
                n_fail++;
                $display("FAIL long_done_cycles: got %0d,%0d required 127,130", done_at[0], done_at[1]);
            end
        end
    endtask

    task automatic test_random();
        restart(4'b0000, 7'd3, 7'd2, 7'd1);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_c%0d: got %h required %h", c, obs_vec(), exp_vec());
            end
            n_checks++;
            if ({(lamp_green & lamp_yellow) | (lamp_green & lamp_red) | (lamp_yellow & lamp_red),
                 lamp_green | lamp_yellow | lamp_red} !== {4'h0, 4'hF}) begin
                n_fail++;
                $display("FAIL random_onehot_c%0d: got g=%b y=%b r=%b required one lamp per lane",
                         c, lamp_green, lamp_yellow, lamp_red);
            end
            enable      = ($urandom_range(0, 39) != 0);
            skip_mask   = NL'($urandom_range(0, 15));
            green_time  = TW'($urandom_range(0, 6));
            yellow_time = TW'($urandom_range(0, 4));
            allred_time = TW'($urandom_range(0, 3));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rotation();
        test_skip();
        test_duration_change();
        test_enable_drop();
        test_async_reset();
        test_long_green();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
